// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port simulation RAM between the
// instruction-fetch port (m0) and the load/store port (m1).
// One transaction at a time, round-robin grant, ACCESS timeout, and a
// forced cs-low RELEASE cycle that restarts the RAM's latency counter.
module ram_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  // fetch port
  input  logic            m0_valid,
  input  logic            m0_we,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_ready,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_err,
  // load/store port
  input  logic            m1_valid,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_ready,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_err,
  // RAM bus
  output logic            ram_cs,
  output logic            ram_wr,
  output logic            ram_rd,
  output logic [XLEN-1:0] ram_address,
  output logic [XLEN-1:0] ram_DB_w,
  output logic            ram_valid,
  input  logic [XLEN-1:0] ram_DB_r,
  input  logic            ram_ready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  state_t                 state;
  logic                   last_grant;
  logic                   gnt;
  req_t                   cur;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   timeout;
  logic [1:0]             vld;
  req_t [1:0]             req;
  logic                   pick;
  logic [1:0]             rdy_q;
  logic [1:0]             err_q;
  logic [1:0][XLEN-1:0]   rdata_q;

  assign vld    = {m1_valid, m0_valid};
  assign req[0] = {m0_we, m0_addr, m0_wdata};
  assign req[1] = {m1_we, m1_addr, m1_wdata};

  // Contention goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    pick = vld[1];
    if (vld == 2'b11) pick = ~last_grant;
  end

  assign cnt_nxt = cnt + 1'b1;
  assign timeout = (cnt_nxt == CW'(TIMEOUT_CYCLES));

  // Address and write data come straight from the latched request, so they
  // stay stable for the whole ACCESS phase.
  assign ram_address = cur.addr;
  assign ram_DB_w    = cur.wdata;

  assign m0_ready = rdy_q[0];
  assign m1_ready = rdy_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

  // Sequencer: IDLE grants and latches, ACCESS drives the strobes until ready
  // or timeout, RELEASE drops cs for one cycle while pulsing the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cur        <= '0;
      cnt        <= '0;
      ram_cs     <= 1'b0;
      ram_valid  <= 1'b0;
      ram_wr     <= 1'b0;
      ram_rd     <= 1'b0;
      rdy_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|vld) begin
            gnt        <= pick;
            last_grant <= pick;
            cur        <= req[pick];
            cnt        <= '0;
            ram_cs     <= 1'b1;
            ram_valid  <= 1'b1;
            ram_wr     <= req[pick].we;
            ram_rd     <= ~req[pick].we;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt_nxt;
          // ready wins over a coincident timeout
          if (ram_ready || timeout) begin
            ram_cs       <= 1'b0;
            ram_valid    <= 1'b0;
            ram_wr       <= 1'b0;
            ram_rd       <= 1'b0;
            rdy_q[gnt]   <= 1'b1;
            err_q[gnt]   <= ~ram_ready;
            rdata_q[gnt] <= (ram_ready && !cur.we) ? ram_DB_r : '0;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          rdy_q   <= '0;
          err_q   <= '0;
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: two random masters, a 3-cycle-latency
// RAM model, and a transaction-level reference that predicts grant order,
// timing windows and response data from the port rules.
module tb_ram_port_arbiter;
  localparam int XLEN   = 32;
  localparam int TO     = 16;
  localparam int NCYC   = 4000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            m0_valid, m0_we, m0_ready, m0_err;
  logic [XLEN-1:0] m0_addr, m0_wdata, m0_rdata;
  logic            m1_valid, m1_we, m1_ready, m1_err;
  logic [XLEN-1:0] m1_addr, m1_wdata, m1_rdata;
  logic            ram_cs, ram_wr, ram_rd, ram_valid, ram_ready;
  logic [XLEN-1:0] ram_address, ram_DB_w, ram_DB_r;

  always #5 clk = ~clk;

  ram_port_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_address(ram_address),
    .ram_DB_w(ram_DB_w), .ram_valid(ram_valid), .ram_DB_r(ram_DB_r), .ram_ready(ram_ready)
  );

  // preload pattern; address 5 holds the classic marker word
  function automatic logic [XLEN-1:0] init_val(input int a);
    return (a == 5) ? 32'hDEADBEEF : (32'hA5A5_0000 | 32'(a));
  endfunction

  // RAM model: ready on the 4th consecutive cs-high cycle; stall blocks it
  logic [XLEN-1:0] ram_mem [16];
  logic [15:0]     written = '0;
  logic [2:0]      lat = '0;
  logic            stall = 1'b0;

  assign ram_ready = ram_cs && ram_valid && (lat == 3'd3) && !stall;
  assign ram_DB_r  = written[ram_address[3:0]] ? ram_mem[ram_address[3:0]]
                                               : init_val(int'(ram_address[3:0]));

  always @(posedge clk) begin
    if (!ram_cs) lat <= '0;
    else if (lat != 3'd7) lat <= lat + 3'd1;
    if (ram_ready && ram_wr) begin
      ram_mem[ram_address[3:0]] <= ram_DB_w;
      written[ram_address[3:0]] <= 1'b1;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // reference model state
  logic [XLEN-1:0] ref_mem [16];
  bit              exp_active;
  int              exp_grant, exp_done, exp_port, idle_from, last;
  logic            exp_we, exp_err;
  logic [XLEN-1:0] exp_addr, exp_wdata, exp_rdata;

  // masters
  logic [1:0]      pend;
  logic            mwe   [2];
  logic [XLEN-1:0] maddr [2];
  logic [XLEN-1:0] mwdat [2];

  initial begin
    bit acc, fin;
    int who;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    pend = '0; exp_active = 0; last = 1; idle_from = 0;
    for (int p = 0; p < 2; p++) begin mwe[p] = 0; maddr[p] = '0; mwdat[p] = '0; end
    m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      acc = exp_active && c > exp_grant && c < exp_done;
      fin = exp_active && c == exp_done;

      chk("ram_cs",    32'(ram_cs),    32'(acc));
      chk("ram_valid", 32'(ram_valid), 32'(acc));
      chk("ram_wr",    32'(ram_wr),    32'(acc && exp_we));
      chk("ram_rd",    32'(ram_rd),    32'(acc && !exp_we));
      if (acc) chk("ram_address", ram_address, exp_addr);
      if (acc && exp_we) chk("ram_DB_w", ram_DB_w, exp_wdata);
      chk("m0_ready", 32'(m0_ready), 32'(fin && exp_port == 0));
      chk("m1_ready", 32'(m1_ready), 32'(fin && exp_port == 1));
      chk("m0_rdata", m0_rdata, (fin && exp_port == 0) ? exp_rdata : '0);
      chk("m1_rdata", m1_rdata, (fin && exp_port == 1) ? exp_rdata : '0);
      chk("m0_err", 32'(m0_err), 32'(fin && exp_port == 0 && exp_err));
      chk("m1_err", 32'(m1_err), 32'(fin && exp_port == 1 && exp_err));

      if (fin) begin
        pend[exp_port] = 1'b0;
        exp_active = 0;
        stall = 1'b0;
        if (exp_we && !exp_err) ref_mem[exp_addr[3:0]] = exp_wdata;
      end

      // reset: held for the first cycles, then occasional mid-run pulses
      // (never on the cycle where a RAM write is being accepted)
      if (c < 3) rst = 1'b1;
      else rst = ($urandom_range(0, 149) == 0) && !(exp_active && c == exp_done - 1);
      if (rst) begin
        exp_active = 0; stall = 1'b0; last = 1; idle_from = c + 1;
      end

      // masters hold payload while pending; idle ports wiggle their payload
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) pend[p] = 1'b1;
        if (!pend[p] || (pend[p] && !(exp_active && exp_port == p) && $urandom_range(0, 3) == 0 && 0)) begin
          mwe[p]   = 1'($urandom_range(0, 1));
          maddr[p] = 32'($urandom_range(0, 15));
          mwdat[p] = $urandom();
        end
      end
      // freshly raised requests get a fresh payload too
      m0_valid = pend[0]; m0_we = mwe[0]; m0_addr = maddr[0]; m0_wdata = mwdat[0];
      m1_valid = pend[1]; m1_we = mwe[1]; m1_addr = maddr[1]; m1_wdata = mwdat[1];

      if (!rst && !exp_active && c >= idle_from && pend != 2'b00) begin
        who        = (pend == 2'b11) ? (last == 0 ? 1 : 0) : (pend[0] ? 0 : 1);
        last       = who;
        exp_active = 1;
        exp_port   = who;
        exp_we     = mwe[who];
        exp_addr   = maddr[who];
        exp_wdata  = mwdat[who];
        stall      = ($urandom_range(0, 5) == 0);
        exp_err    = stall;
        exp_grant  = c;
        exp_done   = c + (stall ? TO + 1 : 5);
        exp_rdata  = (stall || exp_we) ? '0 : ref_mem[exp_addr[3:0]];
        idle_from  = exp_done + 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
